// File: rtl/xung_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xung_pkg
// Description : Shared sequencer state encoding and default sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
package xung_pkg;

    localparam int c_NSTEP_DEF = 4;
    localparam int c_DW_DEF    = 8;
    localparam int c_CW_DEF    = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_ADV  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/xung_halfper_gen.sv
`default_nettype none
// ============================================================================
// Module      : xung_halfper_gen
// Description : Half-period counter that toggles clko every div cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module xung_halfper_gen #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clear,
    input  logic [DW-1:0] div,
    output logic          clko,
    output logic          tick,
    output logic          fall
);

    logic [DW-1:0] r_hc;
    logic          r_clko;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = en && (r_hc == (div - DW'(1)));
    // Announces that the coming edge takes clko 1->0, so the FSM can act on it.
    assign fall   = w_wrap && r_clko;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_hc   <= '0;
            r_clko <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (en) begin
                if (w_wrap) begin
                    r_hc   <= '0;
                    r_clko <= ~r_clko;
                    r_tick <= ~r_clko;
                end else begin
                    r_hc <= r_hc + 1'b1;
                end
            end
        end
    end

    assign clko = r_clko;
    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/xung_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : xung_seq_ctrl
// Description : Step-table pulse-train sequencer driving a square-wave output.
// Revision    : 1.0 - initial release
// ============================================================================
module xung_seq_ctrl
    import xung_pkg::*;
#(
    parameter int NSTEP = c_NSTEP_DEF,
    parameter int DW    = c_DW_DEF,
    parameter int CW    = c_CW_DEF
) (
    input  logic                     clki,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [$clog2(NSTEP)-1:0] cfg_addr,
    input  logic [DW-1:0]            cfg_div,
    input  logic [CW-1:0]            cfg_cnt,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NSTEP)-1:0] step_idx,
    output logic                     clko,
    output logic                     tick
);

    localparam int AW = $clog2(NSTEP);

    logic [DW-1:0] r_tbl_div [NSTEP];
    logic [CW-1:0] r_tbl_cnt [NSTEP];

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_step;
    logic [DW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;

    logic          w_last;
    logic          w_skip;
    logic          w_fall;
    logic          w_gen_en;
    logic          w_gen_clear;
    logic          w_busy_nxt;
    logic          w_done_nxt;

    // Table writes are accepted in every state; a running step keeps its latched copy.
    always_ff @(posedge clki) begin
        if (rst) begin
            for (int i = 0; i < NSTEP; i++) begin
                r_tbl_div[i] <= '0;
                r_tbl_cnt[i] <= '0;
            end
        end else if (cfg_we) begin
            r_tbl_div[cfg_addr] <= cfg_div;
            r_tbl_cnt[cfg_addr] <= cfg_cnt;
        end
    end

    assign w_last = (r_step == AW'(NSTEP - 1));
    assign w_skip = (r_tbl_div[r_step] == '0) || (r_tbl_cnt[r_step] == '0);

    always_ff @(posedge clki) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start && !stop) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (stop)        w_state_nxt = S_IDLE;
                else if (w_skip) w_state_nxt = S_ADV;
                else             w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (stop)                              w_state_nxt = S_IDLE;
                else if (w_fall && (r_cnt == CW'(1)))  w_state_nxt = S_ADV;
            end
            S_ADV: begin
                if (stop)                 w_state_nxt = S_IDLE;
                else if (w_last && !loop) w_state_nxt = S_DONE;
                else                      w_state_nxt = S_LOAD;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (w_state_nxt == S_DONE);
        w_gen_en    = (r_state == S_RUN);
        // Clearing on stop drops clko in the same edge that returns to IDLE.
        w_gen_clear = (r_state != S_RUN) || stop;
    end

    always_ff @(posedge clki) begin
        if (rst) begin
            r_step <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;

            if (w_state_nxt == S_IDLE) begin
                r_step <= '0;
            end else if ((r_state == S_ADV) && (w_state_nxt == S_LOAD)) begin
                r_step <= r_step + 1'b1;
            end

            if (r_state == S_LOAD) begin
                r_div <= r_tbl_div[r_step];
                r_cnt <= r_tbl_cnt[r_step];
            end else if ((r_state == S_RUN) && w_fall) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    xung_halfper_gen #(
        .DW (DW)
    ) u_halfper (
        .clk   (clki),
        .rst   (rst),
        .en    (w_gen_en),
        .clear (w_gen_clear),
        .div   (r_div),
        .clko  (clko),
        .tick  (tick),
        .fall  (w_fall)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign step_idx = r_step;

endmodule
`default_nettype wire

// File: tb/tb_xung_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_xung_seq_ctrl
// Description : Self-checking bench: scenario table, corner sequences, random runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xung_seq_ctrl;

    localparam int NSTEP = 4;
    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int AW    = 2;

    logic          clki = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [DW-1:0] cfg_div = '0;
    logic [CW-1:0] cfg_cnt = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop = 1'b0;
    logic          busy;
    logic          done;
    logic [AW-1:0] step_idx;
    logic          clko;
    logic          tick;

    xung_seq_ctrl #(
        .NSTEP (NSTEP),
        .DW    (DW),
        .CW    (CW)
    ) dut (
        .clki     (clki),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_div  (cfg_div),
        .cfg_cnt  (cfg_cnt),
        .start    (start),
        .stop     (stop),
        .loop     (loop),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx),
        .clko     (clko),
        .tick     (tick)
    );

    always #5 clki = ~clki;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          clko;
        logic          tick;
        logic [AW-1:0] idx;
    } exp_t;

    typedef struct {
        int d0, c0, d1, c1;
        int exp_done;
        int exp_ticks;
        int exp_first;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    int   m_div [NSTEP];
    int   m_cnt [NSTEP];
    exp_t exp_q [$];
    vec_t vecs [7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_cyc();
        @(posedge clki);
        #1;
    endtask

    task automatic wr(input int a, input int d, input int c);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_div  = DW'(d);
        cfg_cnt  = CW'(c);
        m_div[a] = d;
        m_cnt[a] = c;
        step_cyc();
        cfg_we   = 1'b0;
    endtask

    task automatic clear_tbl();
        for (int i = 0; i < NSTEP; i++) wr(i, 0, 0);
    endtask

    function automatic exp_t dut_now();
        exp_t e;
        e = {busy, done, clko, tick, step_idx};
        return e;
    endfunction

    task automatic push(input bit b, input bit d, input bit k, input bit t, input int idx);
        exp_t e;
        e.busy = b;
        e.done = d;
        e.clko = k;
        e.tick = t;
        e.idx  = AW'(idx);
        exp_q.push_back(e);
    endtask

    // Expected per-cycle outputs from the cycle after start is sampled: each step
    // is one load cycle, cnt periods of div low + div high (if enabled), one advance cycle.
    task automatic build_trace();
        exp_q.delete();
        for (int s = 0; s < NSTEP; s++) begin
            push(1, 0, 0, 0, s);
            if (m_div[s] > 0 && m_cnt[s] > 0) begin
                for (int p = 0; p < m_cnt[s]; p++) begin
                    for (int h = 0; h < m_div[s]; h++) push(1, 0, 0, 0, s);
                    for (int h = 0; h < m_div[s]; h++) push(1, 0, 1, (h == 0), s);
                end
            end
            push(1, 0, 0, 0, s);
        end
        push(1, 1, 0, 0, NSTEP - 1);
        push(0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0);
    endtask

    // Start sampled at the end of cycle 0; returns cycle numbers relative to that.
    task automatic run_measure(output int done_at, output int ticks, output int first);
        start = 1'b1;
        step_cyc();
        start = 1'b0;
        done_at = 0;
        ticks   = 0;
        first   = 0;
        for (int c = 1; c <= 2000; c++) begin
            if (tick) begin
                ticks++;
                if (first == 0) first = c;
            end
            if (done) begin
                done_at = c;
                break;
            end
            step_cyc();
        end
    endtask

    initial begin
        int d_at, n_t, f_t;
        int tcount, t3_cyc, t3_idx, clk_hi;
        vecs[0] = '{2, 1,   0, 0,  13,   1,   4};
        vecs[1] = '{1, 2,   3, 1,  19,   3,   3};
        vecs[2] = '{0, 5,   5, 0,   9,   0,   0};
        vecs[3] = '{1, 1,   1, 1,  13,   2,   3};
        vecs[4] = '{3, 2,   0, 0,  21,   2,   5};
        vecs[5] = '{255, 1, 0, 0, 519,   1, 257};
        vecs[6] = '{1, 255, 0, 0, 519, 255,   3};
        for (int i = 0; i < NSTEP; i++) begin
            m_div[i] = 0;
            m_cnt[i] = 0;
        end

        step_cyc();
        step_cyc();
        rst = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_clko", clko, 0);
        chk("reset_tick", tick, 0);
        chk("reset_idx", step_idx, 0);

        foreach (vecs[v]) begin
            clear_tbl();
            wr(0, vecs[v].d0, vecs[v].c0);
            wr(1, vecs[v].d1, vecs[v].c1);
            run_measure(d_at, n_t, f_t);
            chk($sformatf("vec%0d_done_cycle", v), d_at, vecs[v].exp_done);
            chk($sformatf("vec%0d_ticks", v), n_t, vecs[v].exp_ticks);
            chk($sformatf("vec%0d_first_tick", v), f_t, vecs[v].exp_first);
            step_cyc();
            chk($sformatf("vec%0d_busy_after", v), busy, 0);
        end

        // Looping single-step pass repeats every 10 cycles until loop is dropped.
        clear_tbl();
        wr(0, 1, 1);
        loop  = 1'b1;
        start = 1'b1;
        step_cyc();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chk("loop_tick", tick, int'(c % 10 == 3));
            chk("loop_no_done", done, 0);
            step_cyc();
        end
        loop = 1'b0;
        d_at = 0;
        for (int c = 41; c <= 80; c++) begin
            if (done) begin
                d_at = c;
                break;
            end
            step_cyc();
        end
        chk("loop_exit_done", d_at, 51);
        step_cyc();

        // Abort while clko is high, then a clean restart from step 0.
        clear_tbl();
        wr(0, 4, 2);
        start = 1'b1;
        step_cyc();
        start = 1'b0;
        clk_hi = 0;
        for (int c = 1; c <= 50; c++) begin
            if (clko) begin
                clk_hi = c;
                break;
            end
            step_cyc();
        end
        chk("abort_clko_rise", clk_hi, 6);
        stop = 1'b1;
        step_cyc();
        stop = 1'b0;
        chk("abort_clko", clko, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_idx", step_idx, 0);
        start = 1'b1;
        stop  = 1'b1;
        step_cyc();
        start = 1'b0;
        stop  = 1'b0;
        chk("stop_start_idle", busy, 0);
        run_measure(d_at, n_t, f_t);
        chk("restart_done_cycle", d_at, 25);
        chk("restart_first_tick", f_t, 6);
        chk("restart_ticks", n_t, 2);
        step_cyc();

        // Rewrite step 1 and pulse start while step 0 runs.
        clear_tbl();
        wr(0, 2, 2);
        start = 1'b1;
        step_cyc();
        start = 1'b0;
        tcount = 0;
        t3_cyc = 0;
        t3_idx = -1;
        d_at   = 0;
        for (int c = 1; c <= 200; c++) begin
            cfg_we = 1'b0;
            start  = 1'b0;
            if (c == 3) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'd1;
                cfg_div  = 8'd4;
                cfg_cnt  = 8'd1;
                start    = 1'b1;
            end
            if (tick) begin
                tcount++;
                if (tcount == 3) begin
                    t3_cyc = c;
                    t3_idx = int'(step_idx);
                end
            end
            if (done) begin
                d_at = c;
                break;
            end
            step_cyc();
        end
        cfg_we = 1'b0;
        start  = 1'b0;
        chk("live_done_cycle", d_at, 25);
        chk("live_ticks", tcount, 3);
        chk("live_step1_tick", t3_cyc, 16);
        chk("live_step1_idx", t3_idx, 1);
        step_cyc();

        // Reset mid-run clears the table; the next run skips every step.
        clear_tbl();
        wr(0, 3, 3);
        start = 1'b1;
        step_cyc();
        start = 1'b0;
        for (int c = 0; c < 8; c++) step_cyc();
        rst = 1'b1;
        step_cyc();
        rst = 1'b0;
        for (int i = 0; i < NSTEP; i++) begin
            m_div[i] = 0;
            m_cnt[i] = 0;
        end
        chk("midrst_busy", busy, 0);
        chk("midrst_clko", clko, 0);
        run_measure(d_at, n_t, f_t);
        chk("midrst_done_cycle", d_at, 1 + 2 * NSTEP);
        chk("midrst_ticks", n_t, 0);
        step_cyc();

        // Random tables, random ignored starts and optional abort, against the trace model.
        for (int it = 0; it < 25; it++) begin
            bit do_stop;
            int k;
            for (int s = 0; s < NSTEP; s++) wr(s, $urandom_range(0, 3), $urandom_range(0, 3));
            build_trace();
            do_stop = ($urandom % 3 == 0);
            k = $urandom_range(0, exp_q.size() - 3);
            start = 1'b1;
            step_cyc();
            start = 1'b0;
            for (int i = 0; i < exp_q.size(); i++) begin
                chk($sformatf("rand%0d_cyc%0d", it, i + 1), int'(dut_now()), int'(exp_q[i]));
                if (do_stop && i == k) begin
                    stop  = 1'b1;
                    start = 1'b0;
                    step_cyc();
                    stop  = 1'b0;
                    chk($sformatf("rand%0d_abort", it), int'(dut_now()), 0);
                    break;
                end
                start = exp_q[i].busy ? 1'($urandom % 2) : 1'b0;
                step_cyc();
            end
            start = 1'b0;
            step_cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xung_seq_ctrl.md
Name: xung_seq_ctrl

Overview:
- Programmable pulse-train sequencer that schedules the clock-divider function of the machtaoxung project.
- Holds a small step table; each entry gives a divide ratio and a pulse count.
- On start, walks the table and emits on clko, for each step, cnt full square-wave periods of 2*div clki cycles, then advances.
- Sits between the host/config logic and the pulse output pin; supports one-shot and looping runs, abort, and live table update.

Parameters:
NSTEP, 4, number of table entries (power of 2, >=2)
DW, 8, divide-ratio width (half-period length in clki cycles)
CW, 8, pulse-count width per step

Ports:
clki  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
cfg_we  in  1  table write strobe
cfg_addr  in  $clog2(NSTEP)  table entry index
cfg_div  in  DW  half-period in clki cycles; 0 = skip step
cfg_cnt  in  CW  number of full periods; 0 = skip step
start  in  1  begin run; sampled only in IDLE
stop  in  1  abort run; priority over start
loop  in  1  sampled in ADV of last step: 1 = wrap to step 0
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on normal completion
step_idx  out  $clog2(NSTEP)  current step
clko  out  1  generated pulse output
tick  out  1  one-cycle pulse in the cycle clko goes 0->1

Behaviour:
- Reset: state IDLE; all outputs 0; all table entries 0; internal counters 0.
- Table writes: allowed in any state. Write takes effect at the next LOAD of that entry; a step already running is unaffected.
- FSM states: IDLE, LOAD, RUN, ADV, DONE. All outputs are registered.
- IDLE: clko=0. start=1 & stop=0 -> LOAD with step_idx=0.
- LOAD (1 cycle):
  - Latch div_r/cnt_r from table[step_idx].
  - If either is 0 -> ADV; else -> RUN with half-counter hc=0, clko=0.
- RUN:
  - hc increments each cycle.
  - When hc==div_r-1: hc<=0, clko toggles.
  - On a 1->0 toggle, cnt_r decrements.
  - If that 1->0 toggle occurs with cnt_r==1: -> ADV, clko=0.
- ADV (1 cycle):
  - If step_idx==NSTEP-1: loop=1 -> step_idx=0, LOAD; else -> DONE.
  - Otherwise step_idx+1, LOAD.
- DONE: done=1 for this cycle only, then -> IDLE.
- Latency: start sampled at edge N -> LOAD at N+1, RUN at N+2, first clko=1 at N+2+div.
- High and low phases are each exactly div_r cycles; clko is 0 between steps (ADV/LOAD gap = 2 cycles low extra).
- stop=1 in any non-IDLE state:
  - Next cycle IDLE, clko=0, done not asserted, step_idx=0.
  - stop in IDLE has no effect.
  - stop & start together in IDLE: stays IDLE.
- start while busy is ignored; it does not restart.
- rst mid-run: immediate return to reset state next edge, table cleared.
- Width rules:
  - hc is DW bits. div=1 gives a toggle every cycle (period 2).
  - div=2^DW-1 and cnt=2^CW-1 are legal, with no overflow.
- All-zero table with start: LOAD/ADV chain through all steps, then DONE. clko never rises. done at N+1+2*NSTEP.

Decomposition:
- Shared package xung_pkg: state enum (IDLE, LOAD, RUN, ADV, DONE), default NSTEP/DW/CW constants.
- One sub-module xung_halfper_gen: hc counter + clko toggle + tick, with inputs en, div, clear. Outputs clko, tick, fall (1->0 toggle strobe). The FSM and table remain in xung_seq_ctrl.

Test Plan:
- Single step: rst; table[0]={div=2,cnt=1}, others 0; start at cycle 0 -> clko=1 cycles 4-5 only, tick at 4, done=1 at cycle 13, busy falls at 14.
- Multi-step: table[0]={1,2}, table[1]={3,1}, others 0 -> clko periods 2,2 then one period of 6; step_idx 0 then 1; done after step 3 ADV.
- Loop: table[0]={1,1}, loop=1 -> pulse repeats every 10 cycles indefinitely, done never asserted. Drop loop -> finishes current pass, then done.
- Abort: stop mid-RUN with clko=1 -> next cycle clko=0, busy=0, done=0; new start then runs from step 0.
- Live rewrite/ignored start: while step 0 runs, write table[1]={4,1} and pulse start -> step 1 uses div=4, no restart occurs.
- Reset mid-run, then start without writes -> all steps skipped, clko stays 0, done at 1+2*NSTEP cycles after start.
